// File: rtl/pdm_capture_pkg.sv
// Shared constants for the PDM capture front end and the CIC stage behind it.
package pdm_capture_pkg;

  localparam int unsigned N_CH             = 8;
  localparam int unsigned DEF_HALF_DIV     = 6;
  localparam int unsigned DEF_SAMPLE_PHASE = 10;
  localparam int unsigned DEF_WORD         = 16;

  // Per-cycle decision taken by the output register
  typedef enum logic [1:0] {
    XFER_IDLE,
    XFER_LOAD,
    XFER_DROP,
    XFER_CONSUME
  } xfer_e;

endpackage

// File: rtl/pdm_capture_if.sv
// Word-set hand-off from the PDM capture block to the downstream CIC stage.
interface pdm_capture_if
  import pdm_capture_pkg::*;
#(
  parameter int unsigned WORD = DEF_WORD
);

  logic [N_CH*WORD-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/pdm_shift_lane.sv
// One microphone channel: shift register with the newest PDM bit entering at the LSB.
module pdm_shift_lane
  import pdm_capture_pkg::*;
#(
  parameter int unsigned WORD = DEF_WORD
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            shift,
  input  logic            bit_in,
  output logic [WORD-1:0] shift_next
);

  logic [WORD-1:0] shift_q;

  // The completed word must include the bit of the completing strobe.
  assign shift_next = {shift_q[WORD-2:0], bit_in};

  always_ff @(posedge clk) begin
    if (clear) begin
      shift_q <= '0;
    end else if (shift) begin
      shift_q <= shift_next;
    end
  end

endmodule

// File: rtl/pdm_capture.sv
// 8-channel PDM capture: pdm_clk generation, din synchronisation, bit packing
// and a one-deep word-set register with overrun detection.
module pdm_capture
  import pdm_capture_pkg::*;
#(
  parameter int unsigned HALF_DIV     = DEF_HALF_DIV,
  parameter int unsigned SAMPLE_PHASE = DEF_SAMPLE_PHASE,
  parameter int unsigned WORD         = DEF_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   din,
  output logic              pdm_clk,
  pdm_capture_if.master     cic_bus,
  output logic              overrun,
  input  logic              clear_overrun
);

  localparam int unsigned PERIOD = 2 * HALF_DIV;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned BIT_W  = $clog2(WORD);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH   = CNT_W'(HALF_DIV);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PHASE);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD - 1);

  logic [CNT_W-1:0]     div_cnt;
  logic [CNT_W-1:0]     div_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [N_CH-1:0]      din_meta;
  logic [N_CH-1:0]      din_sync;
  logic                 strobe;
  logic                 word_done;
  logic                 lane_clear;
  logic [N_CH*WORD-1:0] word_set;
  xfer_e                xfer;

  // Deliberately unreset: the synchronizer only has to flush, not initialise.
  always_ff @(posedge clk) begin
    din_meta <= din;
    din_sync <= din_meta;
  end

  assign div_next   = (div_cnt == CNT_LAST) ? '0 : div_cnt + CNT_W'(1);
  assign strobe     = enable && (div_cnt == CNT_SAMPLE);
  assign word_done  = strobe && (bit_cnt == BIT_LAST);
  assign lane_clear = reset || !enable;

  // pdm_clk is registered from div_next so it always matches the live count.
  always_ff @(posedge clk) begin
    if (lane_clear) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= div_next;
      pdm_clk <= (div_next >= CNT_HIGH);
      if (strobe) begin
        bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
      end
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_lane
    pdm_shift_lane #(
      .WORD (WORD)
    ) u_lane (
      .clk        (clk),
      .clear      (lane_clear),
      .shift      (strobe),
      .bit_in     (din_sync[ch]),
      .shift_next (word_set[ch*WORD +: WORD])
    );
  end

  always_comb begin
    xfer = XFER_IDLE;
    if (word_done) begin
      xfer = (!cic_bus.out_valid || cic_bus.out_ready) ? XFER_LOAD : XFER_DROP;
    end else if (cic_bus.out_valid && cic_bus.out_ready) begin
      xfer = XFER_CONSUME;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cic_bus.out_data  <= '0;
      cic_bus.out_valid <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      unique case (xfer)
        XFER_LOAD: begin
          cic_bus.out_data  <= word_set;
          cic_bus.out_valid <= 1'b1;
        end
        XFER_CONSUME: cic_bus.out_valid <= 1'b0;
        XFER_DROP:    ;
        XFER_IDLE:    ;
      endcase
      if (xfer == XFER_DROP) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_capture.sv
// Directed scenarios plus a randomised soak for pdm_capture, checked every
// cycle against a strobe-level reference model built on a queue of captured bits.
module tb_pdm_capture;
  import pdm_capture_pkg::*;

  localparam int unsigned H  = DEF_HALF_DIV;
  localparam int unsigned SP = DEF_SAMPLE_PHASE;
  localparam int unsigned W  = DEF_WORD;
  localparam int unsigned P  = 2 * H;
  localparam int unsigned DW = N_CH * W;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            clear_overrun;
  logic            pdm_clk;
  logic            overrun;
  logic [N_CH-1:0] din;

  pdm_capture_if #(.WORD(W)) cic_bus ();

  pdm_capture #(
    .HALF_DIV     (H),
    .SAMPLE_PHASE (SP),
    .WORD         (W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .din           (din),
    .pdm_clk       (pdm_clk),
    .cic_bus       (cic_bus),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model state (values after the most recent clock edge)
  int unsigned     m_en_edges = 0;
  logic [N_CH-1:0] m_bits[$];
  logic            m_valid = 1'b0;
  logic            m_ovr   = 1'b0;
  logic [DW-1:0]   m_data  = '0;
  logic            m_strobe = 1'b0;
  logic            m_done   = 1'b0;
  logic [N_CH-1:0] h1 = '0;
  logic [N_CH-1:0] h2 = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic en, input logic rdy,
                            input logic clr, input logic [N_CH-1:0] d);
    logic [N_CH-1:0] b;
    logic [DW-1:0]   nw;
    logic            drop;
    b = h2;
    h2 = h1;
    h1 = d;
    m_strobe = 1'b0;
    m_done   = 1'b0;
    drop     = 1'b0;
    nw       = '0;
    if (r) begin
      m_en_edges = 0;
      m_bits.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovr   = 1'b0;
    end else begin
      if (!en) begin
        m_en_edges = 0;
        m_bits.delete();
      end else begin
        if (m_en_edges % P == SP) begin
          m_strobe = 1'b1;
          m_bits.push_back(b);
        end
        m_en_edges++;
      end
      if (m_bits.size() == W) begin
        m_done = 1'b1;
        for (int c = 0; c < N_CH; c++)
          for (int i = 0; i < W; i++)
            nw[c*W + (W-1-i)] = m_bits[i][c];
        m_bits.delete();
      end
      if (m_done) begin
        if (!m_valid || rdy) begin
          m_data  = nw;
          m_valid = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
  endtask

  task automatic cyc();
    logic r, en, rdy, clr;
    logic [N_CH-1:0] d;
    r = reset; en = enable; rdy = cic_bus.out_ready; clr = clear_overrun; d = din;
    @(posedge clk);
    #1;
    model_edge(r, en, rdy, clr, d);
    chk("pdm_clk", pdm_clk, DW'((m_en_edges % P) >= H));
    chk("out_valid", cic_bus.out_valid, m_valid);
    chk("out_data", cic_bus.out_data, m_data);
    chk("overrun", overrun, m_ovr);
  endtask

  function automatic logic completes_next();
    return !reset && enable && (m_en_edges % P == SP) && (m_bits.size() == W - 1);
  endfunction

  task automatic run_until_done(input string tag, input bit rnd);
    int n;
    n = 0;
    do begin
      if (rnd) din = N_CH'($urandom);
      cyc();
      n++;
    end while (!m_done && n < 400);
    if (!m_done) chk({"timeout_", tag}, 0, 1);
  endtask

  initial begin
    int rises, highs, last, nwords, lastv, s, n;
    logic prev;
    logic [DW-1:0] held, pack_exp;

    reset = 1'b1; enable = 1'b0; din = '0; cic_bus.out_ready = 1'b0; clear_overrun = 1'b0;
    repeat (3) cyc();
    chk("rst_pdm_clk", pdm_clk, 0);
    chk("rst_valid", cic_bus.out_valid, 0);
    chk("rst_data", cic_bus.out_data, 0);
    reset = 1'b0;
    cyc();

    // Clock generation: 120 enabled cycles
    enable = 1'b1; cic_bus.out_ready = 1'b1;
    rises = 0; highs = 0; last = -1; prev = pdm_clk;
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (pdm_clk && !prev) begin
        if (last >= 0) chk("clk_period", DW'(i - last), DW'(P));
        last = i;
        rises++;
      end
      if (pdm_clk) highs++;
      prev = pdm_clk;
    end
    chk("clk_rises", DW'(rises), 10);
    chk("clk_high_cycles", DW'(highs), 60);

    // Packing: ch0 alternates starting with 1, ch7 constant 1
    enable = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0; din = 8'h81; enable = 1'b1;
    pack_exp = '0;
    pack_exp[0 +: W] = 16'hAAAA;
    pack_exp[7*W +: W] = 16'hFFFF;
    s = 0; nwords = 0; lastv = -1;
    for (int t = 0; t < 600; t++) begin
      cyc();
      if (m_strobe) begin
        s++;
        din = {1'b1, 6'b0, (s % 2 == 0)};
      end
      if (cic_bus.out_valid) begin
        chk("pack_word", cic_bus.out_data, pack_exp);
        if (lastv >= 0) chk("pack_interval", DW'(t - lastv), 192);
        lastv = t;
        nwords++;
      end
    end
    chk("pack_words", DW'(nwords), 3);

    // Backpressure: hold first word, drop the second
    cic_bus.out_ready = 1'b0;
    run_until_done("bp_first", 1);
    held = m_data;
    run_until_done("bp_second", 1);
    chk("bp_held_data", cic_bus.out_data, held);
    chk("bp_overrun", overrun, 1);
    cic_bus.out_ready = 1'b1;
    cyc();
    chk("bp_accept", cic_bus.out_valid, 0);
    run_until_done("bp_third", 1);
    chk("bp_third_load", cic_bus.out_valid, 1);

    // Ready in the exact completion cycle; then clear coincident with a drop
    clear_overrun = 1'b1;
    cyc();
    clear_overrun = 1'b0;
    chk("clr_overrun", overrun, 0);
    cic_bus.out_ready = 1'b0;
    run_until_done("sim_hold", 1);
    n = 0;
    do begin
      cic_bus.out_ready = completes_next();
      din = N_CH'($urandom);
      cyc();
      n++;
      if (!m_done) chk("sim_no_gap", cic_bus.out_valid, 1);
    end while (!m_done && n < 400);
    chk("sim_valid", cic_bus.out_valid, 1);
    chk("sim_overrun", overrun, 0);
    cic_bus.out_ready = 1'b0;
    n = 0;
    do begin
      clear_overrun = completes_next();
      din = N_CH'($urandom);
      cyc();
      n++;
    end while (!m_done && n < 400);
    clear_overrun = 1'b0;
    chk("clr_vs_drop", overrun, 1);
    clear_overrun = 1'b1;
    cyc();
    clear_overrun = 1'b0;
    chk("clr_after", overrun, 0);

    // Reset after 9 strobes into a word
    cic_bus.out_ready = 1'b1;
    run_until_done("rst_align", 1);
    n = 0; s = 0;
    while (s < 9 && n < 200) begin
      din = N_CH'($urandom);
      cyc();
      if (m_strobe) s++;
      n++;
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_pdm_clk", pdm_clk, 0);
    chk("midrst_valid", cic_bus.out_valid, 0);
    chk("midrst_data", cic_bus.out_data, 0);
    chk("midrst_overrun", overrun, 0);
    run_until_done("midrst_word", 1);
    chk("midrst_word_valid", cic_bus.out_valid, 1);

    // Enable toggle with a held word waiting
    cic_bus.out_ready = 1'b0;
    run_until_done("en_hold", 1);
    s = 0; n = 0;
    while (s < 5 && n < 200) begin
      din = N_CH'($urandom);
      cyc();
      if (m_strobe) s++;
      n++;
    end
    enable = 1'b0;
    repeat (20) cyc();
    chk("en_off_pdm_clk", pdm_clk, 0);
    chk("en_off_held", cic_bus.out_valid, 1);
    cic_bus.out_ready = 1'b1;
    cyc();
    chk("en_off_deliver", cic_bus.out_valid, 0);
    cic_bus.out_ready = 1'b0;
    enable = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!pdm_clk && n < 50);
    chk("en_restart_rise", DW'(n), 6);

    // Randomised soak
    for (int i = 0; i < 3000; i++) begin
      din = N_CH'($urandom);
      cic_bus.out_ready = ($urandom_range(0, 3) != 0);
      clear_overrun = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/pdm_capture.md
PDM_CAPTURE -- requirements
Module: pdm_capture

Interface
REQ-001 Parameter HALF_DIV, default 6: system clocks per half period of pdm_clk, legal range 2..255.
REQ-002 Parameter SAMPLE_PHASE, default 10: divider count at which synchronized din is sampled, legal range 0..2*HALF_DIV-1.
REQ-003 Parameter WORD, default 16: PDM bits packed per channel word, legal range 2..32.
REQ-004 clk  in  1  system clock; all logic is on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  capture enable; when 0, the divider and packer are held idle.
REQ-007 din  in  8  raw PDM data, one bit per microphone; asynchronous to clk.
REQ-008 pdm_clk  out  1  microphone clock, driven to the pads.
REQ-009 out_data  out  8*WORD  packed words; channel n occupies bits [n*WORD +: WORD]; the oldest bit is the MSB.
REQ-010 out_valid  out  1  out_data holds an unconsumed word set.
REQ-011 out_ready  in  1  the downstream CIC stage accepts out_data.
REQ-012 overrun  out  1  sticky flag: a completed word set was dropped.
REQ-013 clear_overrun  in  1  clears overrun.

Function
REQ-014 The divider count shall run from 0 to 2*HALF_DIV-1 and wrap; pdm_clk shall be 1 when the count is >= HALF_DIV, else 0, and shall be registered.
REQ-015 Each din bit shall pass through a 2-flop synchronizer before use; the synchronizer shall not be reset.
REQ-016 A sample strobe shall fire in every cycle where the divider count equals SAMPLE_PHASE, giving exactly one strobe per pdm_clk period.
REQ-017 On each strobe, every channel shift register shall shift left with the synchronized bit inserted at the LSB, and the bit counter shall increment.
REQ-018 On the strobe that brings the bit counter to WORD, all 8 shift results, including that strobe's bit, shall be offered for transfer to out_data, and the bit counter shall return to 0.
REQ-019 Transfer rule, no valid word held (out_valid=0): load out_data and set out_valid=1 in the next cycle.
REQ-020 Transfer rule, valid word held and out_ready=1 in the completing cycle: the old word is consumed, the new word loads, and out_valid stays 1.
REQ-021 Transfer rule, valid word held and out_ready=0: drop the new word, keep out_data unchanged, and set overrun.
REQ-022 A handshake shall occur when out_valid and out_ready are both 1; with no new word completing in that cycle, out_valid shall clear in the next cycle.
REQ-023 out_data shall remain stable while out_valid=1 and no handshake occurs.
REQ-024 clear_overrun=1 shall clear overrun in the next cycle; if a drop occurs in the same cycle, the set shall win.
REQ-025 With enable=0, the divider count, bit counter, and shift registers shall be held at 0, and pdm_clk shall be 0.
REQ-026 With enable=0, out_data, out_valid, overrun, and the handshake shall keep operating.
REQ-027 After enable rises, the divider shall start from count 0 in the next cycle.
REQ-028 Latency from a din edge to its capture shall be at most 2 synchronizer cycles plus the wait to the next strobe.

Reset
REQ-029 While reset=1: pdm_clk=0, out_valid=0, overrun=0, out_data=0, divider count=0, bit counter=0, and shift registers=0.
REQ-030 Reset shall take priority over enable, clear_overrun, and out_ready.
REQ-031 Reset mid-word shall discard the partial word without raising overrun.

Structure
REQ-032 The shared package shall hold the channel count constant (8) and the default HALF_DIV, SAMPLE_PHASE, and WORD values, for reuse by the CIC stage and the top level.
REQ-033 The per-channel shift register and bit insertion shall be one sub-module, pdm_shift_lane, instantiated 8 times; the divider and handshake logic stay in pdm_capture.

Verification
REQ-034 Scenario, clock generation: defaults, enable=1 for 120 cycles -> pdm_clk period exactly 12 cycles with 6 high, and exactly 10 strobes.
REQ-035 Scenario, packing: din[0] driven to alternate 1,0 per strobe starting with 1, din[7]=1 constantly, others 0, out_ready=1 -> each word set has ch0=16'hAAAA, ch7=16'hFFFF, others 16'h0000, and out_valid pulses once per 192 cycles.
REQ-036 Scenario, backpressure and overrun: out_ready=0 for 2 full words -> the first word is held unchanged, the second is dropped, and overrun=1; then out_ready=1 -> the first word is accepted and out_valid=0 until the third word completes.
REQ-037 Scenario, simultaneous events: out_ready asserted in the exact completion cycle while out_valid=1 -> the new word loads with no out_valid gap and overrun stays 0; separately, clear_overrun coincident with a drop -> overrun=1.
REQ-038 Scenario, mid-operation reset: reset after 9 strobes -> all outputs 0 next cycle; after release, the first word contains only bits captured after reset.
REQ-039 Scenario, enable toggle: enable dropped mid-word while a held word waits -> pdm_clk=0 with the held word still deliverable; enable restored -> the first pdm_clk rise occurs 6 cycles after the divider restarts.
